lsu_access_ctrl: RTL

- Multi-cycle load/store sequencer between the execute stage and a handshaked data-memory port.
- Takes control fields decoded by the instruction controller (MemRead, MemWrite, Mem_mode = func3, Mem_read_us) plus the effective address and store data.
- Drives a req/ready memory bus with byte strobes, stalls the pipeline while a transfer is in flight, and returns aligned, sign- or zero-extended load data to writeback.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_data_align.sv | 60 ++++++
 rtl/lsu_access_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and constants for the load/store unit.
//                - FSM state enum for the access sequencer
//                - transfer-size codes, as derived from func3[1:0]
//                - func3 load/store encodings, shared with the decoder
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } lsu_state_e;

    // Transfer size codes (func3[1:0]; 2'b11 is treated as word)
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // func3 encodings, shared with the instruction controller
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Map func3 to a transfer size; the reserved 2'b11 code becomes a word
    function automatic logic [1:0] size_of(input logic [2:0] func3);
        return (func3[1:0] == 2'b11) ? SZ_W : func3[1:0];
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_data_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_data_align
//  Description : Purely combinational data formatting for the LSU.
//                Store side: lane replication and byte-strobe generation.
//                Load side : byte/half extraction with sign/zero extension.
//  Ports       : i_st_size/i_st_off/i_st_data -> o_st_data, o_st_strb
//                i_ld_size/i_ld_off/i_ld_unsigned/i_ld_word -> o_ld_data
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_st_size,     // store size code
    input  logic [1:0]  i_st_off,      // byte offset, already size-truncated
    input  logic [31:0] i_st_data,     // store source register
    output logic [31:0] o_st_data,     // lane-replicated store data
    output logic [3:0]  o_st_strb,     // byte strobes
    input  logic [1:0]  i_ld_size,     // load size code
    input  logic [1:0]  i_ld_off,      // byte offset, already size-truncated
    input  logic        i_ld_unsigned, // 1 = zero-extend
    input  logic [31:0] i_ld_word,     // raw read word
    output logic [31:0] o_ld_data      // extended load result
);

    logic [31:0] w_ld_shift;

    always_comb begin
        o_st_data = i_st_data;
        o_st_strb = 4'b1111;
        case (i_st_size)
            SZ_B: begin
                o_st_data = {4{i_st_data[7:0]}};
                o_st_strb = 4'b0001 << i_st_off;
            end
            SZ_H: begin
                o_st_data = {2{i_st_data[15:0]}};
                o_st_strb = 4'b0011 << {i_st_off[1], 1'b0};
            end
            default: begin
                o_st_data = i_st_data;
                o_st_strb = 4'b1111;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending
    assign w_ld_shift = i_ld_word >> {i_ld_off, 3'b000};

    always_comb begin
        o_ld_data = i_ld_word;
        case (i_ld_size)
            SZ_B: o_ld_data = {{24{~i_ld_unsigned & w_ld_shift[7]}}, w_ld_shift[7:0]};
            SZ_H: o_ld_data = {{16{~i_ld_unsigned & w_ld_shift[15]}}, w_ld_shift[15:0]};
            default: o_ld_data = i_ld_word;
        endcase
    end

endmodule : lsu_data_align
`default_nettype wire

// File: rtl/lsu_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_access_ctrl
//  Description : Multi-cycle load/store sequencer between execute and a
//                req/ready data-memory port. Stalls the pipeline while a
//                transfer is in flight and returns extended load data.
//  Ports       : clk, rst (sync, active-high)
//                op_valid, MemRead, MemWrite, Mem_mode, Mem_read_us,
//                addr, wdata                      - from execute
//                stall, done, rdata, bus_err, misalign - to pipeline
//                mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
//                mem_ready, mem_rdata             - memory bus
//  Options     : LSU_MISALIGN_TRAP_EN - misaligned half/word accesses are
//                completed without a bus cycle and flagged on misalign.
//                Otherwise offending low address bits are truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_access_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,  // 0 disables the timeout
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Mem_mode,
    input  logic              Mem_read_us,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              bus_err,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] C_TIMEOUT = TMR_W'(TIMEOUT_CYCLES);

    lsu_state_e r_state, w_state_nxt;

    logic [TMR_W-1:0]  r_timer;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [1:0]        r_ld_size;
    logic [1:0]        r_ld_off;
    logic              r_ld_us;
    logic [31:0]       r_rdata;
    logic              r_bus_err;

    logic              w_access;
    logic [1:0]        w_size;
    logic [1:0]        w_off;
    logic [31:0]       w_st_data;
    logic [3:0]        w_st_strb;
    logic [31:0]       w_ld_data;
    logic [TMR_W-1:0]  w_timer_inc;
    logic              w_timeout;
    logic              w_trap;
    logic              w_unused;

    // func3[2] duplicates Mem_read_us, which the decoder already supplies
    assign w_unused = Mem_mode[2];

    assign w_access = op_valid & (MemRead | MemWrite);
    assign w_size   = size_of(Mem_mode);

    // Offset truncated to the natural alignment of the access size
    always_comb begin
        case (w_size)
            SZ_B:    w_off = addr[1:0];
            SZ_H:    w_off = {addr[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misalign;
    assign w_misaligned = ((w_size == SZ_H) && addr[0]) ||
                          ((w_size == SZ_W) && (addr[1:0] != 2'b00));
    assign w_trap   = w_misaligned;
    assign misalign = r_misalign;
`else
    assign w_trap   = 1'b0;
    assign misalign = 1'b0;
`endif

    lsu_data_align u_align (
        .i_st_size     (w_size),
        .i_st_off      (w_off),
        .i_st_data     (wdata),
        .o_st_data     (w_st_data),
        .o_st_strb     (w_st_strb),
        .i_ld_size     (r_ld_size),
        .i_ld_off      (r_ld_off),
        .i_ld_unsigned (r_ld_us),
        .i_ld_word     (mem_rdata),
        .o_ld_data     (w_ld_data)
    );

    // w_timer_inc is the count of unanswered REQ cycles including this one
    assign w_timer_inc = r_timer + 1'b1;
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (w_timer_inc == C_TIMEOUT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_access) w_state_nxt = w_trap ? RESP : REQ;
            REQ:     if (mem_ready || w_timeout) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_ld_size <= '0;
            r_ld_off  <= '0;
            r_ld_us   <= 1'b0;
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        r_timer   <= '0;
                        r_we      <= MemWrite;
                        r_addr    <= {addr[ADDR_W-1:2], 2'b00};
                        r_wdata   <= w_st_data;
                        r_wstrb   <= MemWrite ? w_st_strb : 4'b0000;
                        r_ld_size <= w_size;
                        r_ld_off  <= w_off;
                        r_ld_us   <= Mem_read_us;
`ifdef LSU_MISALIGN_TRAP_EN
                        // Trapped access goes straight to RESP with a clean result
                        if (w_misaligned) begin
                            r_rdata    <= '0;
                            r_bus_err  <= 1'b0;
                            r_misalign <= 1'b1;
                        end
`endif
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        r_rdata   <= r_we ? 32'h0 : w_ld_data;
                        r_bus_err <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                        r_misalign <= 1'b0;
`endif
                    end else begin
                        r_timer <= w_timer_inc;
                        if (w_timeout) begin
                            r_rdata   <= '0;
                            r_bus_err <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                            r_misalign <= 1'b0;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // rst masks the request/handshake outputs in the same cycle so the bus
    // sees the abort without waiting for the state register to clear
    assign mem_req   = (r_state == REQ) & ~rst;
    assign stall     = ~rst & (((r_state == IDLE) & w_access) | (r_state == REQ));
    assign done      = (r_state == RESP) & ~rst;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;
    assign rdata     = r_rdata;
    assign bus_err   = r_bus_err;

endmodule : lsu_access_ctrl
`default_nettype wire
